note_sequencer: RTL

Queued tone sequencer that drives the tone generator's `tone_enable` and `tone_input` inputs without CPU timing involvement. The CPU pushes notes (24-bit tone word plus 8-bit duration) into an on-chip FIFO through the memory-mapped write port. The block plays the notes back-to-back, each for a tick-quantised duration, with an optional silent gap between notes. It replaces direct software writes of the tone enable/value registers when `run` is set.

---
 rtl/note_sequencer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/note_sequencer.sv
// Queued tone sequencer: CPU pushes {duration, tone} entries into a FIFO and the
// playback FSM drives the tone generator back-to-back, with an optional silent gap.
module note_sequencer #(
    parameter int DEPTH       = 8,
    parameter int TICK_CYCLES = 125000,
    parameter int GAP_TICKS   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        sel,
    input  logic [31:0] wdata,
    output logic        tone_enable,
    output logic [23:0] tone_input,
    output logic [31:0] status
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int GAP_W   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

    localparam logic [CNT_W-1:0]   DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'(GAP_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 run_q, run_d;
    logic                 overflow_q, overflow_d;
    logic                 tone_enable_q, tone_enable_d;
    logic [23:0]          tone_input_q, tone_input_d;
    logic [7:0]           dur_q, dur_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [GAP_W-1:0]     gap_q, gap_d;

    logic                 full_s;
    logic                 empty_s;
    logic                 busy_s;
    logic                 push_req_s;
    logic                 push_ok_s;
    logic                 ctrl_we_s;
    logic                 flush_s;
    logic                 abort_s;
    logic                 can_load_s;
    logic                 wrap_s;
    logic                 note_done_s;
    logic                 pop_s;
    logic [31:0]          head_s;
    logic [23:0]          head_tone_s;
    logic [7:0]           head_dur_s;

    assign full_s      = (count_q == DEPTH_C);
    assign empty_s     = (count_q == CNT_W'(0));
    assign busy_s      = (state_q != ST_IDLE);
    assign push_req_s  = we && !sel;
    assign push_ok_s   = push_req_s && !full_s;
    assign ctrl_we_s   = we && sel;
    assign flush_s     = ctrl_we_s && wdata[1];
    // Stopping or flushing wins over any load that would otherwise happen this cycle.
    assign abort_s     = ctrl_we_s && (!wdata[0] || wdata[1]);
    assign can_load_s  = run_q && !empty_s && !abort_s;
    assign wrap_s      = (presc_q == PRESC_MAX);
    assign head_s      = mem_q[rd_ptr_q];
    assign head_tone_s = head_s[23:0];
    assign head_dur_s  = head_s[31:24];

    assign tone_enable = tone_enable_q;
    assign tone_input  = tone_input_q;
    assign status      = {16'h0000, 8'(count_q), 3'b000, overflow_q, empty_s, full_s, busy_s, run_q};

    // Playback FSM: tick timing, end-of-note detection and head-entry load.
    always_comb begin
        state_d       = state_q;
        tone_enable_d = tone_enable_q;
        tone_input_d  = tone_input_q;
        dur_d         = dur_q;
        presc_d       = presc_q;
        gap_d         = gap_q;
        note_done_s   = 1'b0;
        pop_s         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tone_enable_d = 1'b0;
                note_done_s   = 1'b1;
            end
            ST_PLAY: begin
                if (wrap_s) begin
                    presc_d = PRESC_W'(0);
                    dur_d   = dur_q - 8'd1;
                    if (dur_q == 8'd1) begin
                        if (GAP_TICKS == 0) begin
                            note_done_s = 1'b1;
                        end else begin
                            state_d       = ST_GAP;
                            tone_enable_d = 1'b0;
                            gap_d         = GAP_LOAD;
                        end
                    end else begin
                        note_done_s = 1'b0;
                    end
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            ST_GAP: begin
                tone_enable_d = 1'b0;
                if (wrap_s) begin
                    presc_d = PRESC_W'(0);
                    gap_d   = gap_q - GAP_W'(1);
                    if (gap_q == GAP_W'(1)) begin
                        note_done_s = 1'b1;
                    end else begin
                        note_done_s = 1'b0;
                    end
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            default: begin
                state_d       = ST_IDLE;
                tone_enable_d = 1'b0;
            end
        endcase

        if (abort_s) begin
            state_d       = ST_IDLE;
            tone_enable_d = 1'b0;
            presc_d       = PRESC_W'(0);
            dur_d         = 8'd0;
        end else if (note_done_s && can_load_s) begin
            pop_s = 1'b1;
            // A zero-duration entry is discarded; the next entry is examined from IDLE.
            if (head_dur_s != 8'd0) begin
                state_d       = ST_PLAY;
                tone_input_d  = head_tone_s;
                tone_enable_d = (head_tone_s != 24'd0);
                dur_d         = head_dur_s;
                presc_d       = PRESC_W'(0);
            end else begin
                state_d       = ST_IDLE;
                tone_enable_d = 1'b0;
            end
        end else if (note_done_s) begin
            state_d       = ST_IDLE;
            tone_enable_d = 1'b0;
        end else begin
            pop_s = 1'b0;
        end
    end

    // FIFO pointer and occupancy update; flush returns the queue to empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_s) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            count_d  = CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control register updates: run bit and sticky overflow flag.
    always_comb begin
        run_d      = run_q;
        overflow_d = overflow_q;
        if (ctrl_we_s) begin
            run_d = wdata[0];
        end else begin
            run_d = run_q;
        end
        if (push_req_s && full_s) begin
            overflow_d = 1'b1;
        end else if (ctrl_we_s && wdata[2]) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // FIFO storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= PTR_W'(0);
            rd_ptr_q      <= PTR_W'(0);
            count_q       <= CNT_W'(0);
            run_q         <= 1'b0;
            overflow_q    <= 1'b0;
            tone_enable_q <= 1'b0;
            tone_input_q  <= 24'd0;
            dur_q         <= 8'd0;
            presc_q       <= PRESC_W'(0);
            gap_q         <= GAP_W'(0);
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            run_q         <= run_d;
            overflow_q    <= overflow_d;
            tone_enable_q <= tone_enable_d;
            tone_input_q  <= tone_input_d;
            dur_q         <= dur_d;
            presc_q       <= presc_d;
            gap_q         <= gap_d;
        end
    end

endmodule
